// File: rtl/ifetch_queue_if.sv
// Fetch-side bus bundle: instruction-memory request channel plus the
// instruction stream handed to the datapath.
interface ifetch_queue_if #(
    parameter int n = 16
);
    logic         imem_req;
    logic [n-1:0] imem_addr;
    logic         imem_ack;
    logic [n-1:0] imem_rdata;
    logic [n-1:0] instr;
    logic [n-1:0] instr_pc;
    logic         instr_valid;
    logic         instr_ready;

    modport master (
        output imem_req, imem_addr, instr, instr_pc, instr_valid,
        input  imem_ack, imem_rdata, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_pc, instr_valid,
        output imem_ack, imem_rdata, instr_ready
    );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: issues sequential halfword-aligned fetches,
// buffers returned words, and flushes/restarts on redirect.
module ifetch_queue #(
    parameter int n     = 16,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   redirect,
    input  logic [n-1:0]           redirect_pc,
    ifetch_queue_if.master         bus,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DROP = 2'd2;

    localparam logic [PW:0]   FULL = (PW+1)'(DEPTH);
    localparam logic [PW:0]   ONE  = (PW+1)'(1);
    localparam logic [PW-1:0] PONE = PW'(1);
    localparam logic [n-1:0]  TWO  = n'(2);

    logic [1:0]    state, state_nx;
    logic [n-1:0]  fpc, fpc_nx;
    logic          req_q, req_nx;
    logic [n-1:0]  addr_q, addr_nx;
    logic [PW-1:0] wptr, rptr, rptr_nx;
    logic [PW:0]   count_ap, count_nx;
    logic [n-1:0]  q_data [DEPTH];
    logic [n-1:0]  q_pc   [DEPTH];
    logic [n-1:0]  instr_q, instr_pc_q;
    logic [n-1:0]  head_data, head_pc;
    logic [n-1:0]  target;
    logic          accept, pop, push;

    assign target   = {redirect_pc[n-1:1], 1'b0};
    assign accept   = req_q & bus.imem_ack;
    assign pop      = bus.instr_valid & bus.instr_ready;
    assign push     = accept & (state == WAIT) & ~redirect;
    assign count_ap = count - (pop ? ONE : '0);

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = addr_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = (count != '0);

    always_comb begin
        state_nx = state;
        fpc_nx   = redirect ? target : fpc;
        req_nx   = req_q;
        addr_nx  = addr_q;
        case (state)
            IDLE: begin
                if (redirect) begin
                    state_nx = WAIT;
                    req_nx   = 1'b1;
                    addr_nx  = target;
                end else if (count_ap < FULL) begin
                    state_nx = WAIT;
                    req_nx   = 1'b1;
                    addr_nx  = fpc;
                end
            end
            WAIT: begin
                if (accept && redirect) begin
                    addr_nx = target;
                end else if (accept) begin
                    fpc_nx = addr_q + TWO;
                    if (count_ap + ONE < FULL) begin
                        addr_nx = addr_q + TWO;
                    end else begin
                        state_nx = IDLE;
                        req_nx   = 1'b0;
                    end
                end else if (redirect) begin
                    // request stays on the bus until acked; its data is then dropped
                    state_nx = DROP;
                end
            end
            DROP: begin
                if (accept) begin
                    state_nx = WAIT;
                    addr_nx  = fpc_nx;
                end
            end
            default: begin
                state_nx = IDLE;
                req_nx   = 1'b0;
            end
        endcase
    end

    always_comb begin
        count_nx = redirect ? '0 : count_ap + (push ? ONE : '0);
        rptr_nx  = pop ? rptr + PONE : rptr;
        // head register loads the word being pushed when it becomes the head
        if (push && (rptr_nx == wptr)) begin
            head_data = bus.imem_rdata;
            head_pc   = addr_q;
        end else begin
            head_data = q_data[rptr_nx];
            head_pc   = q_pc[rptr_nx];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            fpc        <= '0;
            req_q      <= 1'b0;
            addr_q     <= '0;
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            instr_q    <= '0;
            instr_pc_q <= '0;
        end else begin
            state  <= state_nx;
            fpc    <= fpc_nx;
            req_q  <= req_nx;
            addr_q <= addr_nx;
            count  <= count_nx;
            if (redirect) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                wptr <= push ? wptr + PONE : wptr;
                rptr <= rptr_nx;
            end
            if (count_nx != '0) begin
                instr_q    <= head_data;
                instr_pc_q <= head_pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_data[wptr] <= bus.imem_rdata;
            q_pc[wptr]   <= addr_q;
        end
    end
endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: cycle table for fill/backpressure/redirect, plus
// scoreboarded streaming sequences for cold start, wrap, reset and flush.
module tb_ifetch_queue;
    localparam int N     = 16;
    localparam int DEPTH = 4;

    typedef struct {
        logic        rdy;
        logic        ack;
        logic        rd;
        logic [15:0] rpc;
        logic        e_req;
        logic [15:0] e_addr;
        logic [2:0]  e_cnt;
        logic [15:0] e_pc;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic [2:0]  count;
    int          n_checks = 0;
    int          n_fail = 0;
    vec_t        tbl [15];
    logic [15:0] sbq [$];

    ifetch_queue_if #(.n(N)) bus ();

    ifetch_queue #(.n(N), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .bus         (bus),
        .count       (count)
    );

    always #5 clk = ~clk;

    // memory model: every word is its address xor a fixed pattern
    assign bus.imem_rdata = bus.imem_addr ^ 16'hA5A5;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        bus.imem_ack = 1'b0;
        bus.instr_ready = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic run_stream(input string tag, input int budget);
        int cyc = 0;
        int bubbles = 0;
        bit seen = 1'b0;
        logic [15:0] e;
        while (sbq.size() != 0 && cyc < budget) begin
            if (bus.instr_valid) begin
                seen = 1'b1;
                if (bus.instr_ready) begin
                    e = sbq.pop_front();
                    chk({tag, ".pc"}, 32'(bus.instr_pc), 32'(e));
                    chk({tag, ".instr"}, 32'(bus.instr), 32'(e ^ 16'hA5A5));
                end
            end else if (seen) begin
                bubbles++;
            end
            tick();
            cyc++;
        end
        chk({tag, ".remaining"}, 32'(sbq.size()), 32'd0);
        chk({tag, ".bubbles"}, 32'(bubbles), 32'd0);
        sbq.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //             rdy  ack  rd   rpc       req  addr      cnt   pc
        tbl[0]  = '{1'b0,1'b0,1'b0,16'h0000, 1'b1,16'h0000,3'd0,16'h0000};
        tbl[1]  = '{1'b0,1'b1,1'b0,16'h0000, 1'b1,16'h0002,3'd1,16'h0000};
        tbl[2]  = '{1'b0,1'b1,1'b0,16'h0000, 1'b1,16'h0004,3'd2,16'h0000};
        tbl[3]  = '{1'b0,1'b1,1'b0,16'h0000, 1'b1,16'h0006,3'd3,16'h0000};
        tbl[4]  = '{1'b0,1'b1,1'b0,16'h0000, 1'b0,16'h0006,3'd4,16'h0000};
        tbl[5]  = '{1'b0,1'b1,1'b0,16'h0000, 1'b0,16'h0006,3'd4,16'h0000};
        tbl[6]  = '{1'b1,1'b1,1'b0,16'h0000, 1'b1,16'h0008,3'd3,16'h0002};
        tbl[7]  = '{1'b0,1'b1,1'b0,16'h0000, 1'b0,16'h0008,3'd4,16'h0002};
        tbl[8]  = '{1'b0,1'b1,1'b0,16'h0000, 1'b0,16'h0008,3'd4,16'h0002};
        tbl[9]  = '{1'b1,1'b0,1'b0,16'h0000, 1'b1,16'h000A,3'd3,16'h0004};
        tbl[10] = '{1'b1,1'b1,1'b0,16'h0000, 1'b1,16'h000C,3'd3,16'h0006};
        tbl[11] = '{1'b1,1'b0,1'b1,16'h0101, 1'b1,16'h000C,3'd0,16'h0006};
        tbl[12] = '{1'b1,1'b1,1'b0,16'h0000, 1'b1,16'h0100,3'd0,16'h0006};
        tbl[13] = '{1'b0,1'b0,1'b0,16'h0000, 1'b1,16'h0100,3'd0,16'h0006};
        tbl[14] = '{1'b0,1'b1,1'b0,16'h0000, 1'b1,16'h0102,3'd1,16'h0100};

        bus.imem_ack = 1'b0;
        bus.instr_ready = 1'b0;
        tick();
        tick();
        chk("rst.req", 32'(bus.imem_req), 32'd0);
        chk("rst.addr", 32'(bus.imem_addr), 32'd0);
        chk("rst.count", 32'(count), 32'd0);
        chk("rst.valid", 32'(bus.instr_valid), 32'd0);
        chk("rst.instr", 32'(bus.instr), 32'd0);
        chk("rst.pc", 32'(bus.instr_pc), 32'd0);
        reset = 1'b1;

        foreach (tbl[i]) begin
            bus.instr_ready = tbl[i].rdy;
            bus.imem_ack = tbl[i].ack;
            redirect = tbl[i].rd;
            redirect_pc = tbl[i].rpc;
            tick();
            chk($sformatf("v%0d.req", i), 32'(bus.imem_req), 32'(tbl[i].e_req));
            if (tbl[i].e_req)
                chk($sformatf("v%0d.addr", i), 32'(bus.imem_addr), 32'(tbl[i].e_addr));
            chk($sformatf("v%0d.count", i), 32'(count), 32'(tbl[i].e_cnt));
            chk($sformatf("v%0d.valid", i), 32'(bus.instr_valid), 32'(tbl[i].e_cnt != 3'd0));
            chk($sformatf("v%0d.pc", i), 32'(bus.instr_pc), 32'(tbl[i].e_pc));
            if (tbl[i].e_cnt != 3'd0)
                chk($sformatf("v%0d.instr", i), 32'(bus.instr), 32'(tbl[i].e_pc ^ 16'hA5A5));
        end
        redirect = 1'b0;

        // cold start streaming
        do_reset();
        bus.instr_ready = 1'b1;
        bus.imem_ack = 1'b1;
        for (int i = 0; i < 10; i++) sbq.push_back(16'(2 * i));
        run_stream("cold", 40);

        // redirect + accept + pop on one edge, then address wrap
        redirect = 1'b1;
        redirect_pc = 16'hFFFC;
        tick();
        redirect = 1'b0;
        chk("sim.count", 32'(count), 32'd0);
        chk("sim.valid", 32'(bus.instr_valid), 32'd0);
        chk("sim.req", 32'(bus.imem_req), 32'd1);
        chk("sim.addr", 32'(bus.imem_addr), 32'hFFFC);
        sbq.push_back(16'hFFFC);
        sbq.push_back(16'hFFFE);
        sbq.push_back(16'h0000);
        sbq.push_back(16'h0002);
        run_stream("wrap", 20);

        // mid-run reset with three entries queued and a request pending
        do_reset();
        tick();
        bus.imem_ack = 1'b1;
        tick();
        tick();
        tick();
        bus.imem_ack = 1'b0;
        chk("mrst.pre_count", 32'(count), 32'd3);
        chk("mrst.pre_addr", 32'(bus.imem_addr), 32'h0006);
        bus.imem_ack = 1'b1;
        reset = 1'b0;
        #1;
        chk("mrst.req", 32'(bus.imem_req), 32'd0);
        chk("mrst.addr", 32'(bus.imem_addr), 32'd0);
        chk("mrst.count", 32'(count), 32'd0);
        chk("mrst.valid", 32'(bus.instr_valid), 32'd0);
        chk("mrst.instr", 32'(bus.instr), 32'd0);
        chk("mrst.pc", 32'(bus.instr_pc), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        chk("mrst.first_req", 32'(bus.imem_req), 32'd1);
        chk("mrst.first_addr", 32'(bus.imem_addr), 32'd0);
        chk("mrst.first_count", 32'(count), 32'd0);
        tick();
        chk("mrst.push_count", 32'(count), 32'd1);
        chk("mrst.push_pc", 32'(bus.instr_pc), 32'd0);

        // redirect while the request at 6 is still waiting for its ack
        tick();
        tick();
        bus.imem_ack = 1'b0;
        chk("fly.pre_addr", 32'(bus.imem_addr), 32'h0006);
        redirect = 1'b1;
        redirect_pc = 16'h0101;
        tick();
        redirect = 1'b0;
        chk("fly.count", 32'(count), 32'd0);
        chk("fly.hold_req", 32'(bus.imem_req), 32'd1);
        chk("fly.hold_addr", 32'(bus.imem_addr), 32'h0006);
        tick();
        chk("fly.hold2_addr", 32'(bus.imem_addr), 32'h0006);
        bus.imem_ack = 1'b1;
        tick();
        chk("fly.drop_count", 32'(count), 32'd0);
        chk("fly.new_addr", 32'(bus.imem_addr), 32'h0100);
        bus.instr_ready = 1'b1;
        sbq.push_back(16'h0100);
        sbq.push_back(16'h0102);
        sbq.push_back(16'h0104);
        run_stream("fly", 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 Parameter n, default 16: instruction and address width in bits.
REQ-002 Parameter DEPTH, default 4: number of queue entries; a power of two, at least 2.
REQ-003 clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low; 0 resets all state immediately.
REQ-005 redirect  input  1  taken branch or jump: flush the queue and restart fetch.
REQ-006 redirect_pc  input  n  restart address; bit 0 is ignored and treated as 0.
REQ-007 imem_req  output  1  instruction-memory read request, registered.
REQ-008 imem_addr  output  n  read address, registered, always even.
REQ-009 imem_ack  input  1  memory has returned data for the current request.
REQ-010 imem_rdata  input  n  returned instruction word; valid only when imem_ack=1.
REQ-011 instr  output  n  head instruction, passed to the datapath instr input.
REQ-012 instr_pc  output  n  address of the head instruction.
REQ-013 instr_valid  output  1  queue is not empty.
REQ-014 instr_ready  input  1  consumer takes the head entry when instr_valid=1.
REQ-015 count  output  $clog2(DEPTH)+1  current queue occupancy.

Function
REQ-016 The fetch FSM SHALL have three states:
- IDLE: no request outstanding.
- WAIT: request outstanding.
- DROP: request outstanding whose data is discarded.
REQ-017 fpc SHALL be the next fetch address, an n-bit register.
REQ-018 A request accept SHALL be any rising edge with imem_req=1 and imem_ack=1.
REQ-019 A pop SHALL be any rising edge with instr_valid=1 and instr_ready=1.
REQ-020 IDLE to WAIT: occurs when redirect=0 and count after any pop is less than DEPTH; sets imem_req=1 and imem_addr=fpc.
REQ-021 While imem_req=1, imem_req and imem_addr SHALL stay constant until the accepting edge.
REQ-022 WAIT accept with redirect=0:
- push {imem_rdata, imem_addr} to the queue tail;
- set fpc=imem_addr+2;
- if occupancy after push and pop is less than DEPTH, stay in WAIT with imem_addr=imem_addr+2 (back-to-back, no bubble);
- otherwise go to IDLE with imem_req=0.
REQ-023 Address arithmetic SHALL be modulo 2^n; 16'hFFFE+2 = 16'h0000 with no flag.
REQ-024 redirect=1 on any edge:
- empty the queue (count=0), overriding a simultaneous pop or push;
- set fpc={redirect_pc[n-1:1],1'b0}.
REQ-025 Redirect target of the next request:
- redirect in IDLE: next state WAIT with imem_addr equal to the new fpc;
- redirect in WAIT without accept: next state DROP; imem_req and imem_addr stay held;
- redirect in WAIT with accept: that data is discarded; next state WAIT with imem_addr equal to the new fpc.
REQ-026 In DROP, an accept SHALL discard the data and move to WAIT at fpc.
REQ-027 A further redirect in DROP SHALL update fpc only.
REQ-028 Push and pop on the same edge SHALL leave count unchanged; this is legal when full or empty-with-push.
REQ-029 A push SHALL never occur when count=DEPTH; the issue rule prevents it.
REQ-030 When instr_valid=0, instr and instr_pc SHALL hold their last values.
REQ-031 While instr_valid=1 and instr_ready=0, instr and instr_pc SHALL stay stable.
REQ-032 There SHALL be no bypass: pushed data appears on instr the edge after the accept at the earliest.
REQ-033 Queue read and write pointers SHALL wrap modulo DEPTH.

Reset
REQ-034 While reset=0, all of the following SHALL hold:
- state=IDLE, fpc=0, pointers=0;
- count=0, instr_valid=0, imem_req=0, imem_addr=0;
- instr=0, instr_pc=0.
REQ-035 Reset asserted mid-request SHALL abandon the request; an imem_ack arriving after release while in IDLE is ignored.
REQ-036 On the first rising edge after reset goes to 1, the block SHALL assert imem_req=1 with imem_addr=0.

Verification
REQ-037 Cold start: release reset, instr_ready=1, imem_ack=1 every cycle with rdata=addr^16'hA5A5 -> instr_pc 0,2,4,... on consecutive cycles; instr matches; no bubbles.
REQ-038 Fill and backpressure: instr_ready=0, ack every cycle -> count reaches 4; imem_req drops to 0; head is stable at pc 0; raising ready for 1 cycle -> exactly one new request, at addr 8.
REQ-039 Redirect in flight: imem_req high at addr 6 with ack withheld; pulse redirect to 16'h0101 -> count=0; on the next ack the data is discarded; next request is at addr 16'h0100; nothing from addr 6 is delivered.
REQ-040 Simultaneous events: redirect, accept and pop on one edge -> count=0; next imem_addr=redirect target; the popped and accepted words never appear later.
REQ-041 Wrap: redirect to 16'hFFFC with ack every cycle -> instr_pc sequence FFFC, FFFE, 0000, 0002.
REQ-042 Mid-run reset: assert reset=0 while in WAIT with count=3 -> all outputs 0 immediately; after release, the first request is at addr 0.
